// File: rtl/cool_heat_controller.sv
// Fan/heater sequencer: hysteresis mode decision, ramped duty command and
// relay enables with a forced ramp-down and dead-time on every stop.
module cool_heat_controller #(
    parameter logic [7:0] COOL_ON     = 8'd35,
    parameter logic [7:0] COOL_OFF    = 8'd30,
    parameter logic [7:0] HEAT_ON     = 8'd15,
    parameter logic [7:0] HEAT_OFF    = 8'd20,
    parameter logic [7:0] GAIN        = 8'd8,
    parameter logic [7:0] MIN_SPEED   = 8'd32,
    parameter logic [7:0] RAMP_DIV    = 8'd16,
    parameter logic [7:0] RAMP_STEP   = 8'd4,
    parameter logic [7:0] DEAD_CYCLES = 8'd64
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    output logic [7:0] speed,
    output logic       cooler_en,
    output logic       heater_en,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_COOL = 3'd1,
        S_HEAT = 3'd2,
        S_STOP = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        M_NONE = 2'd0,
        M_COOL = 2'd1,
        M_HEAT = 2'd2
    } mode_t;

    state_t      st, st_d;
    mode_t       mode, mode_d;
    logic [7:0]  temp_q;
    logic        have_temp;
    logic [7:0]  tick_cnt;
    logic [7:0]  dead_cnt, dead_d;
    logic [7:0]  speed_d;
    logic [7:0]  target;
    logic [7:0]  diff;
    logic [15:0] prod;
    logic        run;
    logic        tick;

    assign tick  = (tick_cnt == RAMP_DIV - 8'd1);
    assign state = st;

    // A leaving COOL/HEAT cycle already aims at zero, so no underflow.
    always_comb begin
        prod = '0;
        run  = 1'b0;
        unique case (st)
            S_COOL: begin
                run  = (temp_q >= COOL_OFF);
                prod = 16'(temp_q - COOL_OFF) * 16'(GAIN);
            end
            S_HEAT: begin
                run  = (temp_q <= HEAT_OFF);
                prod = 16'(HEAT_OFF - temp_q) * 16'(GAIN);
            end
            default: ;
        endcase
        target = '0;
        if (run) begin
            target = (prod > 16'd255) ? 8'hff : prod[7:0];
            if (target < MIN_SPEED)
                target = MIN_SPEED;
        end
    end

    always_comb begin
        speed_d = speed;
        diff    = '0;
        if (tick) begin
            if (speed < target) begin
                diff    = target - speed;
                speed_d = speed + ((diff > RAMP_STEP) ? RAMP_STEP : diff);
            end else if (speed > target) begin
                diff    = speed - target;
                speed_d = speed - ((diff > RAMP_STEP) ? RAMP_STEP : diff);
            end
        end
    end

    always_comb begin
        st_d   = st;
        mode_d = mode;
        dead_d = dead_cnt;
        unique case (st)
            S_IDLE: begin
                if (have_temp && temp_q >= COOL_ON) begin
                    st_d   = S_COOL;
                    mode_d = M_COOL;
                end else if (have_temp && temp_q <= HEAT_ON) begin
                    st_d   = S_HEAT;
                    mode_d = M_HEAT;
                end
            end
            S_COOL: if (temp_q < COOL_OFF) st_d = S_STOP;
            S_HEAT: if (temp_q > HEAT_OFF) st_d = S_STOP;
            S_STOP: begin
                if (speed == 8'd0) begin
                    st_d   = S_DEAD;
                    mode_d = M_NONE;
                    dead_d = DEAD_CYCLES - 8'd1;
                end
            end
            S_DEAD: begin
                if (dead_cnt == 8'd0)
                    st_d = S_IDLE;
                else
                    dead_d = dead_cnt - 8'd1;
            end
            default: begin
                st_d   = S_IDLE;
                mode_d = M_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            st        <= S_IDLE;
            mode      <= M_NONE;
            temp_q    <= '0;
            have_temp <= 1'b0;
            tick_cnt  <= '0;
            dead_cnt  <= '0;
            speed     <= '0;
            cooler_en <= 1'b0;
            heater_en <= 1'b0;
        end else begin
            if (temp_valid) begin
                temp_q    <= temp;
                have_temp <= 1'b1;
            end
            tick_cnt  <= tick ? 8'd0 : tick_cnt + 8'd1;
            st        <= st_d;
            mode      <= mode_d;
            dead_cnt  <= dead_d;
            speed     <= speed_d;
            cooler_en <= (mode_d == M_COOL);
            heater_en <= (mode_d == M_HEAT);
        end
    end

endmodule

// File: tb/tb_cool_heat_controller.sv
// Bench for cool_heat_controller: cycle model compared every cycle plus
// directed scenarios with hand-computed expectations.
module tb_cool_heat_controller;

    localparam int COOL_ON = 35, COOL_OFF = 30, HEAT_ON = 15, HEAT_OFF = 20;
    localparam int GAIN = 8, MIN_SPEED = 32, RAMP_DIV = 16, RAMP_STEP = 4;
    localparam int DEAD_CYCLES = 64;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] temp = '0;
    logic       temp_valid = 1'b0;
    logic [7:0] speed;
    logic       cooler_en, heater_en;
    logic [2:0] state;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 0;

    cool_heat_controller dut (
        .clk(clk), .arst(arst), .temp(temp), .temp_valid(temp_valid),
        .speed(speed), .cooler_en(cooler_en), .heater_en(heater_en),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // Model: states 0..4, mode 0 none / 1 cool / 2 heat.
    int m_st, m_mode, m_spd, m_tq, m_have, m_cyc, m_dead;
    bit m_rst;

    function automatic int target_of(int s, int tq);
        int t;
        if (s == 1 && tq >= COOL_OFF) t = (tq - COOL_OFF) * GAIN;
        else if (s == 2 && tq <= HEAT_OFF) t = (HEAT_OFF - tq) * GAIN;
        else return 0;
        if (t > 255) t = 255;
        return (t < MIN_SPEED) ? MIN_SPEED : t;
    endfunction

    always @(posedge clk) begin
        int tgt, d, ns;
        m_rst = !arst;
        if (!arst) begin
            m_st = 0; m_mode = 0; m_spd = 0; m_tq = 0;
            m_have = 0; m_cyc = 0; m_dead = 0;
        end else begin
            tgt = target_of(m_st, m_tq);
            ns = m_st;
            case (m_st)
                0: if (m_have && m_tq >= COOL_ON) begin ns = 1; m_mode = 1; end
                   else if (m_have && m_tq <= HEAT_ON) begin ns = 2; m_mode = 2; end
                1: if (m_tq < COOL_OFF) ns = 3;
                2: if (m_tq > HEAT_OFF) ns = 3;
                3: if (m_spd == 0) begin ns = 4; m_mode = 0; m_dead = 0; end
                default: if (m_dead == DEAD_CYCLES - 1) ns = 0;
                         else m_dead++;
            endcase
            if (m_cyc % RAMP_DIV == RAMP_DIV - 1) begin
                d = tgt - m_spd;
                if (d > RAMP_STEP) d = RAMP_STEP;
                if (d < -RAMP_STEP) d = -RAMP_STEP;
                m_spd += d;
            end
            m_st = ns;
            m_cyc++;
            if (temp_valid) begin m_tq = temp; m_have = 1; end
        end
    end

    logic [7:0] p_spd;
    logic       p_c, p_h;
    bit         p_ok = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model speed", speed, m_spd);
            chk("model state", state, m_st);
            chk("model cooler_en", cooler_en, m_mode == 1);
            chk("model heater_en", heater_en, m_mode == 2);
            chk("enables exclusive", cooler_en && heater_en, 0);
            if (p_ok && !m_rst && p_spd != 0)
                chk("enable stable while running", {cooler_en, heater_en},
                    {p_c, p_h});
            p_spd = speed; p_c = cooler_en; p_h = heater_en; p_ok = 1;
        end
    end

    task automatic pulse(input int v);
        temp = 8'(v);
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    function automatic int cur(input int w);
        return (w == 0) ? int'(speed) : int'(state);
    endfunction

    int last_wait;
    task automatic wait_for(input string nm, input int w, input int v,
                            input int max);
        int n = 0;
        while (cur(w) != v && n < max) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk(nm, cur(w), v);
    endtask

    task automatic dead_len(input string nm);
        int n = 0;
        while (state == 3'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, DEAD_CYCLES);
        chk({nm, " then idle"}, state, 0);
    endtask

    initial begin
        arst = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("reset state", state, 0);
        chk("reset speed", speed, 0);
        chk("reset enables", {cooler_en, heater_en}, 0);
        arst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: cooling ramp to 80
        pulse(40);
        chk("t1 latency idle", state, 0);
        @(negedge clk);
        chk("t1 cool", state, 1);
        chk("t1 cooler_en", cooler_en, 1);
        chk("t1 heater_en", heater_en, 0);
        wait_for("t1 speed 80", 0, 80, 400);
        chk("t1 ramp time ok", last_wait <= 336, 1);
        repeat (40) @(negedge clk);
        chk("t1 hold 80", speed, 80);

        // 2: stop, ramp down, dead-time
        pulse(28);
        @(negedge clk);
        chk("t2 stop", state, 3);
        chk("t2 cooler held", cooler_en, 1);
        wait_for("t2 dead", 1, 4, 400);
        chk("t2 dead speed", speed, 0);
        chk("t2 dead cooler", cooler_en, 0);
        dead_len("t2 dead len");

        // 3: hysteresis and saturation
        pulse(32);
        repeat (4) @(negedge clk);
        chk("t3 stay idle", state, 0);
        chk("t3 idle speed", speed, 0);
        pulse(36);
        @(negedge clk);
        chk("t3 cool", state, 1);
        wait_for("t3 speed 48", 0, 48, 300);
        pulse(32);
        wait_for("t3 speed 32", 0, 32, 300);
        chk("t3 still cool", state, 1);
        pulse(70);
        wait_for("t3 speed 255", 0, 255, 1200);
        repeat (40) @(negedge clk);
        chk("t3 hold 255", speed, 255);
        pulse(28);
        wait_for("t3 back idle", 1, 0, 2000);

        // 4: heating
        pulse(5);
        @(negedge clk);
        chk("t4 heat", state, 2);
        chk("t4 heater_en", heater_en, 1);
        wait_for("t4 speed 120", 0, 120, 600);
        pulse(0);
        wait_for("t4 speed 160", 0, 160, 300);
        pulse(21);
        @(negedge clk);
        chk("t4 stop", state, 3);
        wait_for("t4 dead", 1, 4, 800);
        dead_len("t4 dead len");

        // 5: changeover cool -> heat
        pulse(40);
        wait_for("t5 speed 80", 0, 80, 400);
        pulse(10);
        wait_for("t5 dead", 1, 4, 500);
        chk("t5 dead enables", {cooler_en, heater_en}, 0);
        dead_len("t5 dead len");
        @(negedge clk);
        chk("t5 heat", state, 2);
        chk("t5 heater_en", heater_en, 1);
        pulse(21);
        wait_for("t5 back idle", 1, 0, 800);

        // 6: reset mid-ramp
        pulse(40);
        wait_for("t6 speed 44", 0, 44, 300);
        arst = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        chk("t6 speed", speed, 0);
        chk("t6 enables", {cooler_en, heater_en}, 0);
        chk("t6 state", state, 0);
        repeat (40) @(negedge clk);
        chk("t6 no have_temp", state, 0);
        pulse(40);
        @(negedge clk);
        chk("t6 cool again", state, 1);
        repeat (20) @(negedge clk);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
